instr_prefetch: RTL and testbench
=================================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, the instruction and PC width.
REQ-002 The block SHALL have parameter DEPTH, default 4, the queue entry count; legal values are powers of two from 2 to 16.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port imem_req, output, 1: a fetch request is issued this cycle.
REQ-006 Port imem_addr, output, 8: the word address of the request, equal to fetch_pc[9:2].
REQ-007 Port imem_rdata, input, WORD_SIZE: the instruction word, valid exactly one cycle after imem_req.
REQ-008 Port instr_valid, output, 1: the queue head is valid.
REQ-009 Port instr_out, output, WORD_SIZE: the instruction at the queue head.
REQ-010 Port instr_pc, output, WORD_SIZE: the byte PC of instr_out.
REQ-011 Port instr_ready, input, 1: the consumer accepts the head this cycle.
REQ-012 Port redirect_valid, input, 1: a taken branch or jump; flush and refetch.
REQ-013 Port redirect_pc, input, WORD_SIZE: the redirect target byte address; bits [1:0] are ignored.
REQ-014 Port occupancy, output, log2(DEPTH)+1: the number of valid queue entries.

Function
REQ-015 An internal fetch_pc register SHALL hold the next byte PC to request, and SHALL advance by 4 on every issued request, wrapping modulo 2^WORD_SIZE.
REQ-016 imem_req SHALL be high exactly when (occupancy + inflight) < DEPTH and redirect_valid is low; inflight is a 1-bit flag set by a request and cleared the next cycle.
REQ-017 Each response SHALL be pushed into the queue, together with the PC of its request, on the edge that ends the response cycle; the queue therefore never overflows.
REQ-018 A head entry SHALL be popped when instr_valid and instr_ready are both high.
REQ-019 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-020 Queue pointers SHALL wrap modulo DEPTH.
REQ-021 instr_valid SHALL be high exactly when occupancy is greater than 0.
REQ-022 When instr_valid is low, instr_out SHALL be 0 and instr_pc SHALL be fetch_pc.
REQ-023 On a redirect, all of the following SHALL happen on the next edge:
- the queue is emptied (occupancy=0), and a pop in the same cycle is discarded;
- any in-flight response is marked killed and is not pushed;
- fetch_pc becomes {redirect_pc[WORD_SIZE-1:2],2'b00}.
REQ-024 The first request after a redirect SHALL issue in the cycle following it.
REQ-025 A redirect SHALL take priority over push, pop and request.
REQ-026 Consecutive redirects SHALL use the last target.
REQ-027 Latency SHALL be: request in cycle N, response in N+1, instr_valid in N+2 when the queue was empty; redirect in cycle R gives instr_valid in R+3.
REQ-028 With instr_ready held high and no redirects, the block SHALL sustain one instruction per cycle after fill.
REQ-029 imem_addr SHALL wrap from 255 to 0 while fetch_pc keeps counting.

Reset
REQ-030 While rst is high, all of the following SHALL hold:
- fetch_pc=0, occupancy=0, inflight=0, kill=0;
- queue pointers are 0;
- imem_req=0, instr_valid=0, instr_out=0, instr_pc=0.
REQ-031 The first request SHALL issue, with imem_addr=0, in the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all queued and in-flight data.
REQ-033 A response arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-034 The DEPTH default, the PC increment (4) and the word-address slice bounds SHALL live in a shared package, cpu_pkg, alongside the existing opcode and ALU constants.
REQ-035 The queue SHALL be a sub-module, sync_fifo, parameterised by width (2*WORD_SIZE) and depth, with push, pop, flush, full, empty and count.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Reset release, instr_ready=1, memory word k = k: instr_valid first in cycle 2 after release, then instr_out = 0,1,2,… with instr_pc = 0,4,8,… one per cycle.
- instr_ready=0 for 10 cycles: exactly 4 requests (PCs 0,4,8,12), occupancy=4, imem_req stays low; raise instr_ready: next request is PC 16.
- redirect_valid with redirect_pc=0x43 while 3 entries are queued and one response is in flight: occupancy=0 next cycle, in-flight word never appears, first request imem_addr=0x10, first output instr_pc=0x40.
- Redirect in the same cycle as a pop with the queue full: occupancy=0 and no extra instruction delivered.
- Fetch across 0x3FC→0x400: imem_addr 255→0, instr_pc 0x3FC then 0x400.
- rst asserted mid-stream with 2 entries queued: outputs zero immediately (asynchronously), and after release delivery restarts at PC 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types: opcodes, ALU operations and the
// instruction-fetch geometry used by the prefetch queue.
package cpu_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int PC_INCR       = 4;
    localparam int IMEM_ADDR_HI  = 9;
    localparam int IMEM_ADDR_LO  = 2;
    localparam int IMEM_ADDR_W   = IMEM_ADDR_HI - IMEM_ADDR_LO + 1;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush; the head entry is always visible
// on rdata_o so the consumer sees it without a read strobe.
module sync_fifo
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    // A push into a full queue is accepted only when the head leaves that same cycle.
    assign doPop  = pop_i & ~empty_o & ~flush_i;
    assign doPush = push_i & (~full_o | doPop) & ~flush_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: streams sequential instruction words into a small
// queue ahead of the decoder and restarts from a new target on a redirect.
module instr_prefetch
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0]   imem_rdata,
    output logic                   instr_valid,
    output logic [WORD_SIZE-1:0]   instr_out,
    output logic [WORD_SIZE-1:0]   instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [WORD_SIZE-1:0]   redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = 2 * WORD_SIZE;

    logic [WORD_SIZE-1:0] fetchPc_q, fetchPc_d;
    logic [WORD_SIZE-1:0] reqPc_q, reqPc_d;
    logic                 inflight_q, inflight_d;
    logic                 kill_q, kill_d;

    logic                 fifoPush;
    logic                 fifoPop;
    logic                 fifoEmpty;
    logic [CNT_W-1:0]     fifoCount;
    logic [ENTRY_W-1:0]   fifoRdata;
    logic [SUM_W-1:0]     reservedSlots;
    logic                 unusedFifoFull;
    logic                 unusedRedirectLsbs;

    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    // Slots already promised to an outstanding response count as taken, so the queue can never overflow.
    assign reservedSlots = {1'b0, fifoCount} + SUM_W'(inflight_q);
    assign imem_req      = ~rst & ~redirect_valid & (reservedSlots < SUM_W'(DEPTH));
    assign imem_addr     = fetchPc_q[IMEM_ADDR_HI:IMEM_ADDR_LO];

    assign fifoPush = inflight_q & ~kill_q & ~redirect_valid;
    assign fifoPop  = instr_valid & instr_ready & ~redirect_valid;

    assign instr_valid = ~fifoEmpty;
    assign instr_out   = instr_valid ? fifoRdata[WORD_SIZE-1:0] : '0;
    assign instr_pc    = instr_valid ? fifoRdata[ENTRY_W-1:WORD_SIZE] : fetchPc_q;
    assign occupancy   = fifoCount;

    // A redirect wins over everything; kill guards against any response still owed to the old stream.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        reqPc_d    = reqPc_q;
        inflight_d = imem_req;
        kill_d     = redirect_valid;
        if (redirect_valid) begin
            fetchPc_d = {redirect_pc[WORD_SIZE-1:2], 2'b00};
        end else if (imem_req) begin
            fetchPc_d = fetchPc_q + WORD_SIZE'(PC_INCR);
            reqPc_d   = fetchPc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q  <= '0;
            reqPc_q    <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            reqPc_q    <= reqPc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .flush_i (redirect_valid),
        .wdata_i ({reqPc_q, imem_rdata}),
        .rdata_o (fifoRdata),
        .full_o  (unusedFifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: memory word k holds k, every scenario
// starts from a fresh reset and checks hand-computed cycle-by-cycle values.
module tb_instr_prefetch;

    localparam int WORD_SIZE = 32;
    localparam int DEPTH     = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 imem_req;
    logic [7:0]           imem_addr;
    logic [WORD_SIZE-1:0] imem_rdata = '0;
    logic                 instr_valid;
    logic [WORD_SIZE-1:0] instr_out;
    logic [WORD_SIZE-1:0] instr_pc;
    logic                 instr_ready = 1'b0;
    logic                 redirect_valid = 1'b0;
    logic [WORD_SIZE-1:0] redirect_pc = '0;
    logic [2:0]           occupancy;

    int checks = 0;
    int errors = 0;

    instr_prefetch #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // One-cycle memory: word k holds k; a cycle without a request returns a poison value.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? WORD_SIZE'(imem_addr) : 32'hBADBAD00;
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset(input logic ready);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = ready;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0h want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h want 0", instr_valid); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %0h want 0", instr_out); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %0h want 0", instr_pc); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %0h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        doReset(1'b1);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stream_req0: got %0h want 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL stream_addr0: got %0h want 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_valid0: got %0h want 0", instr_valid); end
        nextCycle();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_valid1: got %0h want 0", instr_valid); end
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("[TB] FAIL stream_addr1: got %0h want 1", imem_addr); end
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid k=%0d: got %0h want 1", k, instr_valid); end
            checks++; if (instr_out !== 32'(k)) begin errors++; $display("[TB] FAIL stream_out k=%0d: got %0h want %0h", k, instr_out, k); end
            checks++; if (instr_pc !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_pc k=%0d: got %0h want %0h", k, instr_pc, 4 * k); end
        end
    endtask

    task automatic test_stall();
        int           reqCount;
        logic [7:0]   reqAddr [4];
        reqCount = 0;
        doReset(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) nextCycle();
            if (imem_req === 1'b1) begin
                if (reqCount < 4) reqAddr[reqCount] = imem_addr;
                reqCount++;
            end
        end
        checks++; if (reqCount !== 4) begin errors++; $display("[TB] FAIL stall_reqcount: got %0d want 4", reqCount); end
        for (int i = 0; i < 4; i++) begin
            if (i < reqCount) begin
                checks++; if (reqAddr[i] !== 8'(i)) begin errors++; $display("[TB] FAIL stall_addr%0d: got %0h want %0h", i, reqAddr[i], i); end
            end
        end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL stall_occ: got %0d want 4", occupancy); end
        nextCycle();
        instr_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_full: got %0h want 0", imem_req); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL stall_head: got %0h want 0", instr_out); end
        nextCycle();
        checks++; if (occupancy !== 3'd3) begin errors++; $display("[TB] FAIL stall_occ_after: got %0d want 3", occupancy); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume_req: got %0h want 1", imem_req); end
        checks++; if (imem_addr !== 8'h04) begin errors++; $display("[TB] FAIL stall_resume_addr: got %0h want 4", imem_addr); end
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("[TB] FAIL stall_next_pc: got %0h want 4", instr_pc); end
    endtask

    task automatic test_redirect();
        doReset(1'b0);
        repeat (4) nextCycle();
        checks++; if (occupancy !== 3'd3) begin errors++; $display("[TB] FAIL redir_pre_occ: got %0d want 3", occupancy); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_blocked: got %0h want 0", imem_req); end
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL redir_occ: got %0d want 0", occupancy); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid: got %0h want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redir_req: got %0h want 1", imem_req); end
        checks++; if (imem_addr !== 8'h10) begin errors++; $display("[TB] FAIL redir_addr: got %0h want 10", imem_addr); end
        checks++; if (instr_pc !== 32'h40) begin errors++; $display("[TB] FAIL redir_idle_pc: got %0h want 40", instr_pc); end
        nextCycle();
        instr_ready = 1'b1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid_r2: got %0h want 0", instr_valid); end
        nextCycle();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_valid_r3: got %0h want 1", instr_valid); end
        checks++; if (instr_out !== 32'h10) begin errors++; $display("[TB] FAIL redir_out0: got %0h want 10", instr_out); end
        checks++; if (instr_pc !== 32'h40) begin errors++; $display("[TB] FAIL redir_pc0: got %0h want 40", instr_pc); end
        nextCycle();
        checks++; if (instr_out !== 32'h11) begin errors++; $display("[TB] FAIL redir_out1: got %0h want 11", instr_out); end
        checks++; if (instr_pc !== 32'h44) begin errors++; $display("[TB] FAIL redir_pc1: got %0h want 44", instr_pc); end
    endtask

    task automatic test_back_to_back();
        doReset(1'b0);
        repeat (8) nextCycle();
        checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full: got %0d want 4", occupancy); end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_head_valid: got %0h want 1", instr_valid); end
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL b2b_occ: got %0d want 0", occupancy); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid: got %0h want 0", instr_valid); end
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("[TB] FAIL b2b_idle_pc: got %0h want 100", instr_pc); end
        checks++; if (imem_addr !== 8'h40) begin errors++; $display("[TB] FAIL b2b_addr: got %0h want 40", imem_addr); end
        nextCycle();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_r2: got %0h want 0", instr_valid); end
        nextCycle();
        checks++; if (instr_out !== 32'h40) begin errors++; $display("[TB] FAIL b2b_out0: got %0h want 40", instr_out); end
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("[TB] FAIL b2b_pc0: got %0h want 100", instr_pc); end
        nextCycle();
        checks++; if (instr_out !== 32'h41) begin errors++; $display("[TB] FAIL b2b_out1: got %0h want 41", instr_out); end
        checks++; if (instr_pc !== 32'h104) begin errors++; $display("[TB] FAIL b2b_pc1: got %0h want 104", instr_pc); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0]  expAddr [4];
        logic [31:0] expOut  [6];
        logic [31:0] expPc   [6];
        expAddr = '{8'hFC, 8'hFD, 8'hFE, 8'hFF};
        expOut  = '{32'hFC, 32'hFD, 32'hFE, 32'hFF, 32'h0, 32'h1};
        expPc   = '{32'h3F0, 32'h3F4, 32'h3F8, 32'h3FC, 32'h400, 32'h404};
        doReset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL wrap_req_blocked: got %0h want 0", imem_req); end
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) nextCycle();
            checks++; if (imem_addr !== expAddr[c]) begin errors++; $display("[TB] FAIL wrap_addr c=%0d: got %0h want %0h", c, imem_addr, expAddr[c]); end
        end
        nextCycle();
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL wrap_addr_zero: got %0h want 0", imem_addr); end
        checks++; if (instr_out !== expOut[2]) begin errors++; $display("[TB] FAIL wrap_out2: got %0h want %0h", instr_out, expOut[2]); end
        for (int i = 3; i < 6; i++) begin
            nextCycle();
            checks++; if (instr_out !== expOut[i]) begin errors++; $display("[TB] FAIL wrap_out i=%0d: got %0h want %0h", i, instr_out, expOut[i]); end
            checks++; if (instr_pc !== expPc[i]) begin errors++; $display("[TB] FAIL wrap_pc i=%0d: got %0h want %0h", i, instr_pc, expPc[i]); end
        end
    endtask

    task automatic test_reset_mid();
        doReset(1'b0);
        repeat (3) nextCycle();
        checks++; if (occupancy !== 3'd2) begin errors++; $display("[TB] FAIL rmid_pre_occ: got %0d want 2", occupancy); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_valid: got %0h want 1", instr_valid); end
        rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %0h want 0", instr_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL rmid_occ: got %0d want 0", occupancy); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL rmid_out: got %0h want 0", instr_out); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL rmid_pc: got %0h want 0", instr_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req: got %0h want 0", imem_req); end
        instr_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL rmid_restart_addr: got %0h want 0", imem_addr); end
        repeat (2) nextCycle();
        checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL rmid_out0: got %0h want 0", instr_out); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL rmid_pc0: got %0h want 0", instr_pc); end
        nextCycle();
        checks++; if (instr_out !== 32'h1) begin errors++; $display("[TB] FAIL rmid_out1: got %0h want 1", instr_out); end
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("[TB] FAIL rmid_pc1: got %0h want 4", instr_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
